// File: rtl/fp_sqrt_packer_if.sv
// Handshake and data bundle between the sqrt core, the packer and its consumer.
// The flag signals exist only when SQRT_PACK_FLAGS_EN is defined.
interface fp_sqrt_packer_if #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_sign;
  logic [EXP_W-1:0]          in_exp;
  logic                      in_frac_nz;
  logic [MANT_W:0]           in_root;
  logic                      out_valid;
  logic                      out_ready;
  logic [EXP_W+MANT_W:0]     out_data;
`ifdef SQRT_PACK_FLAGS_EN
  logic                      in_rem_nz;
  logic                      out_invalid;
  logic                      out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_frac_nz, in_root, in_rem_nz, out_ready,
    input  in_ready, out_valid, out_data, out_invalid, out_inexact
  );
  modport slave (
    input  in_valid, in_sign, in_exp, in_frac_nz, in_root, in_rem_nz, out_ready,
    output in_ready, out_valid, out_data, out_invalid, out_inexact
  );
`else
  modport master (
    output in_valid, in_sign, in_exp, in_frac_nz, in_root, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_sign, in_exp, in_frac_nz, in_root, out_ready,
    output in_ready, out_valid, out_data
  );
`endif
endinterface

// File: rtl/fp_sqrt_packer.sv
// Packs the fixed-point sqrt root and operand class into an IEEE-754 single result.
// Define SQRT_PACK_FLAGS_EN to add in_rem_nz and the out_invalid/out_inexact flags.
module fp_sqrt_packer #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int BIAS   = 127
) (
  input logic            clk,
  input logic            rst_n,
  fp_sqrt_packer_if.slave bus
);
  localparam int DATA_W = 1 + EXP_W + MANT_W;
  localparam int E_W    = EXP_W + 1;
  localparam logic [EXP_W-1:0]  EXP_MAX = '1;
  localparam logic [E_W-1:0]    E_OFFS  = E_W'(BIAS - 1);
  localparam logic [DATA_W-1:0] QNAN    = {1'b0, EXP_MAX, 1'b1, {(MANT_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] INF     = {1'b0, EXP_MAX, {MANT_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, NORM, OUT} state_t;

  state_t            state_q, state_d;
  logic [MANT_W:0]   m_q, m_d;
  logic [E_W-1:0]    e_q, e_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [MANT_W:0]   m_shift;
  logic [E_W-1:0]    e_dec;
  logic [E_W-1:0]    e_init;
  logic              accept;
  logic              handshake;
  logic              in_ready_c;
  logic              out_valid_c;
`ifdef SQRT_PACK_FLAGS_EN
  logic              rem_nz_q, rem_nz_d;
  logic              invalid_q, invalid_d;
  logic              inexact_q, inexact_d;
`endif

  // Halved exponent: adding the odd bit keeps odd exponents rounding the right way.
  assign e_init    = ({1'b0, bus.in_exp} + E_OFFS + {{EXP_W{1'b0}}, bus.in_exp[0]}) >> 1;
  assign m_shift   = m_q << 1;
  assign e_dec     = e_q - 1'b1;
  assign accept    = bus.in_valid && (state_q == IDLE);
  assign handshake = (state_q == OUT) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      e_q       <= '0;
      data_q    <= '0;
`ifdef SQRT_PACK_FLAGS_EN
      rem_nz_q  <= 1'b0;
      invalid_q <= 1'b0;
      inexact_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      e_q       <= e_d;
      data_q    <= data_d;
`ifdef SQRT_PACK_FLAGS_EN
      rem_nz_q  <= rem_nz_d;
      invalid_q <= invalid_d;
      inexact_q <= inexact_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    e_d       = e_q;
    data_d    = data_q;
`ifdef SQRT_PACK_FLAGS_EN
    rem_nz_d  = rem_nz_q;
    invalid_d = invalid_q;
    inexact_d = inexact_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          m_d     = bus.in_root;
          e_d     = e_init;
          state_d = OUT;
`ifdef SQRT_PACK_FLAGS_EN
          rem_nz_d  = bus.in_rem_nz;
          invalid_d = 1'b0;
          inexact_d = 1'b0;
`endif
          // Class priority: NaN input, +inf, flushed zero/denormal, negative, normal.
          if (bus.in_exp == EXP_MAX && bus.in_frac_nz) begin
            data_d = QNAN;
`ifdef SQRT_PACK_FLAGS_EN
            invalid_d = 1'b1;
`endif
          end else if (bus.in_exp == EXP_MAX && !bus.in_sign) begin
            data_d = INF;
          end else if (bus.in_exp == '0) begin
            data_d = {bus.in_sign, {(DATA_W-1){1'b0}}};
          end else if (bus.in_sign) begin
            data_d = QNAN;
`ifdef SQRT_PACK_FLAGS_EN
            invalid_d = 1'b1;
`endif
          end else if (bus.in_root[MANT_W]) begin
            data_d = {1'b0, e_init[EXP_W-1:0], bus.in_root[MANT_W-1:0]};
`ifdef SQRT_PACK_FLAGS_EN
            inexact_d = bus.in_rem_nz;
`endif
          end else if (bus.in_root == '0) begin
            data_d = '0;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        m_d = m_shift;
        e_d = e_dec;
        if (e_dec == '0) begin
          data_d  = '0;
          state_d = OUT;
        end else if (m_shift[MANT_W]) begin
          data_d  = {1'b0, e_dec[EXP_W-1:0], m_shift[MANT_W-1:0]};
          state_d = OUT;
`ifdef SQRT_PACK_FLAGS_EN
          inexact_d = rem_nz_q;
`endif
        end
      end
      OUT: begin
        if (handshake) begin
          state_d = IDLE;
`ifdef SQRT_PACK_FLAGS_EN
          invalid_d = 1'b0;
          inexact_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = (state_q == IDLE);
    out_valid_c = (state_q == OUT);
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = data_q;
`ifdef SQRT_PACK_FLAGS_EN
  assign bus.out_invalid = invalid_q;
  assign bus.out_inexact = inexact_q;
`endif

endmodule

// File: tb/tb_fp_sqrt_packer.sv
// Directed-vector bench for fp_sqrt_packer: normal packing, normalisation shifts,
// specials, backpressure and asynchronous reset during normalisation.
module tb_fp_sqrt_packer;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   lat;

  fp_sqrt_packer_if bus ();

  fp_sqrt_packer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    tests++;
    if (obs !== expd) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expd);
    end
  endtask

  // Present one operand on a falling edge; it is accepted on the next rising edge.
  task automatic applyStimulus(input logic s, input logic [7:0] e, input logic f,
                               input logic [23:0] r, input logic rem);
    @(negedge clk);
    bus.in_sign    = s;
    bus.in_exp     = e;
    bus.in_frac_nz = f;
    bus.in_root    = r;
`ifdef SQRT_PACK_FLAGS_EN
    bus.in_rem_nz  = rem;
`endif
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.in_exp     = ~e;
    bus.in_root    = ~r;
    bus.in_sign    = ~s;
  endtask

  task automatic waitOutput(output int cycles);
    cycles = 1;
    while (!bus.out_valid && cycles < 64) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic runOp(input string tag, input logic s, input logic [7:0] e, input logic f,
                       input logic [23:0] r, input logic rem, input logic [31:0] data,
                       input int expLat, input logic inv, input logic inex);
    int l;
    applyStimulus(s, e, f, r, rem);
    waitOutput(l);
    checkOutput({tag, ".valid"}, {31'b0, bus.out_valid}, 32'h1);
    checkOutput({tag, ".data"}, bus.out_data, data);
    checkOutput({tag, ".lat"}, 32'(l), 32'(expLat));
`ifdef SQRT_PACK_FLAGS_EN
    checkOutput({tag, ".invalid"}, {31'b0, bus.out_invalid}, {31'b0, inv});
    checkOutput({tag, ".inexact"}, {31'b0, bus.out_inexact}, {31'b0, inex});
`endif
    @(posedge clk);
    #1;
    checkOutput({tag, ".done"}, {30'b0, bus.out_valid, bus.in_ready}, 32'h1);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_sign    = 1'b0;
    bus.in_exp     = '0;
    bus.in_frac_nz = 1'b0;
    bus.in_root    = '0;
    bus.out_ready  = 1'b1;
`ifdef SQRT_PACK_FLAGS_EN
    bus.in_rem_nz  = 1'b0;
`endif
    rst_n = 1'b0;
    #3;
    checkOutput("reset.out_valid", {31'b0, bus.out_valid}, 32'h0);
    checkOutput("reset.in_ready", {31'b0, bus.in_ready}, 32'h1);
    checkOutput("reset.out_data", bus.out_data, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    runOp("sqrt4",     1'b0, 8'd129, 1'b0, 24'h800000, 1'b0, 32'h40000000,  1, 1'b0, 1'b0);
    runOp("sqrt2",     1'b0, 8'd128, 1'b0, 24'hB504F3, 1'b1, 32'h3FB504F3,  1, 1'b0, 1'b1);
    runOp("norm2",     1'b0, 8'd129, 1'b0, 24'h200000, 1'b0, 32'h3F000000,  3, 1'b0, 1'b0);
    runOp("norm1",     1'b0, 8'd130, 1'b0, 24'h400001, 1'b1, 32'h3F800002,  2, 1'b0, 1'b1);
    runOp("norm23",    1'b0, 8'd129, 1'b0, 24'h000001, 1'b0, 32'h34800000, 24, 1'b0, 1'b0);
    runOp("minexp",    1'b0, 8'd1,   1'b0, 24'h800000, 1'b0, 32'h20000000,  1, 1'b0, 1'b0);
    runOp("nan_in",    1'b0, 8'd255, 1'b1, 24'h800000, 1'b1, 32'h7FC00000,  1, 1'b1, 1'b0);
    runOp("pos_inf",   1'b0, 8'd255, 1'b0, 24'h800000, 1'b1, 32'h7F800000,  1, 1'b0, 1'b0);
    runOp("neg_num",   1'b1, 8'd130, 1'b0, 24'h800000, 1'b1, 32'h7FC00000,  1, 1'b1, 1'b0);
    runOp("neg_zero",  1'b1, 8'd0,   1'b0, 24'h000000, 1'b0, 32'h80000000,  1, 1'b0, 1'b0);
    runOp("neg_inf",   1'b1, 8'd255, 1'b0, 24'h000000, 1'b0, 32'h7FC00000,  1, 1'b1, 1'b0);
    runOp("denorm",    1'b0, 8'd0,   1'b1, 24'h400000, 1'b1, 32'h00000000,  1, 1'b0, 1'b0);
    runOp("zero_root", 1'b0, 8'd127, 1'b0, 24'h000000, 1'b0, 32'h00000000,  1, 1'b0, 1'b0);

    // Backpressure: result must hold and new requests must be refused.
    bus.out_ready = 1'b0;
    applyStimulus(1'b0, 8'd129, 1'b0, 24'h800000, 1'b0);
    waitOutput(lat);
    checkOutput("bp.data", bus.out_data, 32'h40000000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_exp   = 8'd200;
      bus.in_root  = 24'h123456;
      @(posedge clk);
      #1;
      checkOutput("bp.hold_data", bus.out_data, 32'h40000000);
      checkOutput("bp.hold_flags", {30'b0, bus.out_valid, bus.in_ready}, 32'h2);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp.release", {30'b0, bus.out_valid, bus.in_ready}, 32'h1);
    @(posedge clk);
    #1;
    checkOutput("bp.idle", {30'b0, bus.out_valid, bus.in_ready}, 32'h1);

    // Reset while normalising a root with 23 leading zeros.
    applyStimulus(1'b0, 8'd129, 1'b0, 24'h000001, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst.busy", {30'b0, bus.out_valid, bus.in_ready}, 32'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst.async", {30'b0, bus.out_valid, bus.in_ready}, 32'h1);
    checkOutput("rst.data", bus.out_data, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    runOp("after_rst", 1'b0, 8'd129, 1'b0, 24'h800000, 1'b0, 32'h40000000, 1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_sqrt_packer.md
Name: fp_sqrt_packer

Overview:
- Downstream stage of the fixed-point square-root core.
- Takes the 24-bit root, plus the sign, exponent and fraction class of the original IEEE-754 single operand, and produces the packed single-precision sqrt result.
- Normalises a root with leading zeros by iterative left shift, one bit per cycle.
- Handles zero, infinity, NaN and negative operands; uses a valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent field width.
- MANT_W, 23, stored fraction width. The root width is MANT_W+1.
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream has a root and operand info
- in_ready  output  1  block can accept; high only in IDLE
- in_sign  input  1  sign of original operand X
- in_exp  input  EXP_W  biased exponent of X
- in_frac_nz  input  1  fraction field of X is nonzero
- in_root  input  MANT_W+1  sqrt core result, Q1.23; bit 23 is the integer bit
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts
- out_data  output  32  IEEE-754 single result

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, out_valid=0, out_data=0, in_ready=1.
  - Internal mantissa and exponent registers are cleared.
- States: IDLE, NORM, OUT.
- IDLE, on in_valid&&in_ready: capture operands and classify.
  - in_exp==255 && in_frac_nz: result 0x7FC00000. Go to OUT.
  - in_exp==255 && !in_frac_nz && !in_sign: result 0x7F800000. Go to OUT.
  - in_exp==0: denormals are flushed. Result {in_sign,31'b0}, i.e. +0 or -0. Go to OUT.
  - in_sign==1 with any other nonzero operand (including -inf): result 0x7FC00000. Go to OUT.
  - Otherwise (normal, positive):
    - e = (in_exp + 126 + in_exp[0]) >> 1, computed 9 bits wide.
    - m = in_root.
    - m[23]==1: go to OUT.
    - m==0: result +0, go to OUT.
    - Otherwise: go to NORM.
- NORM, each cycle: m <= m<<1, e <= e-1.
  - Go to OUT in the cycle where the shifted m[23] becomes 1.
  - If e would reach 0, result +0 and go to OUT (underflow flush).
- OUT:
  - out_valid=1.
  - out_data = {1'b0, e[7:0], m[22:0]} for normal results, or the special value.
  - out_data and out_valid are held stable while out_ready=0.
  - On out_valid&&out_ready: go to IDLE, out_valid=0 next cycle, in_ready=1 next cycle.
- Latency (accept edge to out_valid high): 1 cycle for specials or m[23]=1; 1+lzc(in_root) otherwise.
- Throughput: one result per 2+lzc cycles. There is no accept in the same cycle as an output handshake.
- Rounding: truncation. No rounding is applied to the root.
- in_* are sampled only on the accept edge; changes at other times are ignored.
- A reset asserted in any state aborts the operation immediately; the partial result is discarded.

Optional Feature:
- Macro: SQRT_PACK_FLAGS_EN.
- When defined, the block adds:
  - Input in_rem_nz (1 bit): the sqrt core remainder is nonzero. Sampled on accept.
  - Output out_invalid (1 bit): high with out_valid when the result is the NaN produced by a negative nonzero operand or a NaN input.
  - Output out_inexact (1 bit): high with out_valid when in_rem_nz=1 and the result is a normal number.
  - Both flags reset to 0, are held with out_data, and clear on handshake.
- When undefined, these ports do not exist and behaviour is otherwise identical.

Test Plan:
- sign=0, exp=129, frac_nz=0, root=0x800000, out_ready=1 -> out_data=0x40000000 (sqrt 4 = 2), out_valid 1 cycle after accept.
- sign=0, exp=128, root=0xB504F3 -> out_data=0x3FB504F3 (sqrt 2), latency 1.
- sign=0, exp=129, root=0x200000 -> two NORM shifts, e=126, out_data=0x3F000000, out_valid 3 cycles after accept.
- Specials, issued back to back:
  - exp=255, frac_nz=1 -> 0x7FC00000.
  - exp=255, frac_nz=0, sign=0 -> 0x7F800000.
  - sign=1, exp=130 -> 0x7FC00000 (out_invalid=1 with the macro).
  - sign=1, exp=0 -> 0x80000000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, new in_valid ignored. Release out_ready -> in_ready=1 on the following cycle.
- Reset mid-NORM: root=0x000001 accepted, rst_n low 3 cycles later -> out_valid=0 and in_ready=1 immediately (asynchronously). After release, a new op with exp=129, root=0x800000 yields 0x40000000.
